dsp_mac_ctrl: RTL and testbench
===============================

DSP_MAC_CTRL -- requirements
Module: dsp_mac_ctrl

Interface
REQ-001 SHALL have parameter N_TAPS, default 8, giving samples per dot product; legal range 1..4096.
REQ-002 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports: clr  in  1  synchronous abort, active-high.
REQ-005 SHALL have ports: s_valid  in  1, s_ready  out  1, s_a  in  18, s_b  in  18; sample stream, unsigned.
REQ-006 SHALL have ports: m_valid  out  1, m_ready  in  1, m_data  out  48; result stream.
REQ-007 SHALL have ports to slice: dsp_a  out  18, dsp_b  out  18, dsp_opmode  out  8.
REQ-008 SHALL have ports to slice: dsp_ceab, dsp_cem, dsp_cep, dsp_ceopmode  out  1 each; dsp_p  in  48 (slice P).

Function
REQ-009 SHALL drive a multiplier-accumulator slice with A1/B1, M, P and OPMODE registers enabled and other registers disabled, computing sum of s_a*s_b over N_TAPS samples.
REQ-010 SHALL implement FSM IDLE, FEED, DRAIN, HOLD: IDLE->FEED on first accept; FEED->DRAIN on N_TAPS-th accept; DRAIN->HOLD on result capture; HOLD->IDLE on m_valid&&m_ready.
REQ-011 SHALL assert s_ready in IDLE and FEED only; a sample is accepted on an edge with s_valid&&s_ready.
REQ-012 SHALL register dsp_a/dsp_b and assert dsp_ceab for exactly one cycle after each accept (tag stage 0); otherwise dsp_ceab=0.
REQ-013 SHALL carry a valid/first/last tag through stages 0..3; dsp_cem = stage-1 valid, dsp_cep = stage-2 valid.
REQ-014 SHALL drive dsp_opmode with dsp_ceopmode=1 during stage 1: 8'h01 (X=M, Z=0) when first, 8'h09 (X=M, Z=P) otherwise; carry, pre-add and subtract bits always 0.
REQ-015 SHALL tolerate input bubbles: cycles without an accept insert invalid tags and all slice enables stay 0 for them.
REQ-016 SHALL capture dsp_p into m_data on the edge where the last tag is in stage 3, asserting m_valid 4 edges after the last accept.
REQ-017 SHALL hold m_data and m_valid stable while m_valid&&!m_ready.
REQ-018 SHALL count accepts with a counter of width clog2(N_TAPS+1), cleared on entry to IDLE.
REQ-019 SHALL, on clr, flush all tags, clear the counter, set m_valid=0 and enter IDLE on the next edge; clr overrides any simultaneous handshake.
REQ-020 SHALL require no overflow handling; N_TAPS<=4096 guarantees the sum fits 48 bits.

Reset
REQ-021 SHALL, while rst_n=0, immediately force: state IDLE, all tags 0, counter 0, m_valid=0, m_data=0, dsp_a/dsp_b/dsp_opmode=0 and all dsp_ce*=0.
REQ-022 SHALL assert s_ready=1 in the first cycle after rst_n deasserts.
REQ-023 SHALL make the first result after reset independent of any partial accumulation before reset.

Structure
REQ-024 SHALL place the state enum and the OPM_FIRST=8'h01 and OPM_ACC=8'h09 constants in shared package dsp_mac_pkg.
REQ-025 SHALL implement the 4-stage tag shift register as sub-module mac_tag_pipe; the FSM and counter stay in dsp_mac_ctrl.

Verification (bench instantiates slice with RSTTYPE ASYNC-compatible reset tied from rst_n, N_TAPS=4)
REQ-026 SHALL verify: s_a=1,2,3,4, s_b=2, s_valid continuous -> m_data=20, m_valid 4 edges after last accept.
REQ-027 SHALL verify: same data with s_valid toggling every cycle -> m_data=20; dsp_ceab pulses only on accepts.
REQ-028 SHALL verify: m_ready low 10 cycles -> m_valid=1, m_data=20 stable, s_ready=0 throughout; block a=b=3 x4 follows -> m_data=36 (no carry-over).
REQ-029 SHALL verify: a=b=18'h3FFFF x4 -> m_data=48'h003F_FFE0_0004.
REQ-030 SHALL verify: rst_n low after 2 accepts -> outputs zero same cycle; next block 1,2,3,4 x2 -> 20.
REQ-031 SHALL verify: clr pulse in DRAIN -> IDLE next edge, no m_valid for aborted block, next block correct.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// Shared types and OPMODE constants for the MAC slice controller.
package dsp_mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_HOLD
    } state_e;

    // X=M, Z=0 starts a fresh sum; X=M, Z=P accumulates onto the slice P register.
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// Four-stage tag shifter tracking each sample through slice A1/B1, M, P and result capture.
// One stage per edge, never stalls; flush_i zeroes every stage on the next edge.
module mac_tag_pipe
    import dsp_mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  tag_t       tag_i,
    output logic [3:0] vld_o,
    output logic       first1_o,
    output logic       last3_o
);

    tag_t [3:0] stg_q;
    tag_t [3:0] stg_d;

    always_comb begin
        stg_d = {stg_q[2:0], tag_i};
        if (flush_i) begin
            stg_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_q <= '0;
        end else begin
            stg_q <= stg_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            vld_o[i] = stg_q[i].vld;
        end
    end

    assign first1_o = stg_q[1].first;
    assign last3_o  = stg_q[3].last;

    logic unused_first3;
    assign unused_first3 = stg_q[3].first;

endmodule

// File: rtl/dsp_mac_ctrl.sv
// Feeds N_TAPS samples into a registered MAC slice and returns the 48-bit dot product; result 4 edges after last accept.
// s_ready drops from last accept until the result is taken; m_data/m_valid hold while m_ready is low.
module dsp_mac_ctrl
    import dsp_mac_pkg::*;
#(
    parameter int N_TAPS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ceab,
    output logic        dsp_cem,
    output logic        dsp_cep,
    output logic        dsp_ceopmode,
    input  logic [47:0] dsp_p
);

    localparam int              CW       = $clog2(N_TAPS + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(N_TAPS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          m_valid_q, m_valid_d;
    logic [47:0]   m_data_q, m_data_d;
    logic [17:0]   dsp_a_q, dsp_b_q;

    logic          accept, is_first, is_last, capture;
    tag_t          tag_in;
    logic [3:0]    stg_vld;
    logic          stg1_first, stg3_last;

    assign s_ready  = (state_q == ST_IDLE) || (state_q == ST_FEED);
    assign accept   = s_valid && s_ready && !clr;
    assign is_first = (cnt_q == '0);
    assign is_last  = (cnt_q == LAST_CNT);
    assign tag_in   = '{vld: accept, first: accept && is_first, last: accept && is_last};
    assign capture  = stg_vld[3] && stg3_last && !clr;

    mac_tag_pipe u_tag_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (clr),
        .tag_i    (tag_in),
        .vld_o    (stg_vld),
        .first1_o (stg1_first),
        .last3_o  (stg3_last)
    );

    always_comb begin
        state_d   = state_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE:  if (accept) state_d = is_last ? ST_DRAIN : ST_FEED;
            ST_FEED:  if (accept && is_last) state_d = ST_DRAIN;
            ST_DRAIN: if (capture) state_d = ST_HOLD;
            ST_HOLD:  if (m_valid_q && m_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (capture) begin
            m_valid_d = 1'b1;
            m_data_d  = dsp_p;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        // Abort wins over any handshake landing on the same edge.
        if (clr) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
        end

        if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            dsp_a_q   <= '0;
            dsp_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            if (accept) begin
                dsp_a_q <= s_a;
                dsp_b_q <= s_b;
            end
        end
    end

    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign dsp_a        = dsp_a_q;
    assign dsp_b        = dsp_b_q;
    assign dsp_ceab     = stg_vld[0];
    assign dsp_cem      = stg_vld[1];
    assign dsp_ceopmode = stg_vld[1];
    assign dsp_cep      = stg_vld[2];
    assign dsp_opmode   = stg_vld[1] ? (stg1_first ? OPM_FIRST : OPM_ACC) : 8'h00;

endmodule

// File: tb/tb_dsp_mac_ctrl.sv
// Bench for dsp_mac_ctrl with N_TAPS=4 driving a behavioural registered MAC slice.
module tb_dsp_mac_ctrl;

    localparam int NT = 4;

    logic        clk, rst_n, clr;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [17:0] s_a, s_b, dsp_a, dsp_b;
    logic [47:0] m_data, dsp_p;
    logic [7:0]  dsp_opmode;
    logic        dsp_ceab, dsp_cem, dsp_cep, dsp_ceopmode;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [47:0] exp_q[$];

    dsp_mac_ctrl #(.N_TAPS(NT)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
        .dsp_ceab(dsp_ceab), .dsp_cem(dsp_cem), .dsp_cep(dsp_cep),
        .dsp_ceopmode(dsp_ceopmode), .dsp_p(dsp_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slice: A1/B1, M, OPMODE and P registers, async reset from rst_n.
    logic [17:0] a1_r, b1_r;
    logic [35:0] m_r;
    logic [7:0]  opm_r;
    logic [47:0] p_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_r <= '0; b1_r <= '0; m_r <= '0; opm_r <= '0; p_r <= '0;
        end else begin
            if (dsp_ceab) begin
                a1_r <= dsp_a;
                b1_r <= dsp_b;
            end
            if (dsp_cem)      m_r   <= a1_r * b1_r;
            if (dsp_ceopmode) opm_r <= dsp_opmode;
            if (dsp_cep)      p_r   <= ((opm_r[3:2] == 2'b10) ? p_r : 48'd0)
                                     + ((opm_r[1:0] == 2'b01) ? {12'd0, m_r} : 48'd0);
        end
    end
    assign dsp_p = p_r;

    // dsp_ceab must be high exactly in the cycle following each accept.
    logic acc_prev;
    int   ceab_bad, ceab_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_prev <= 1'b0;
        else        acc_prev <= s_valid && s_ready && !clr;
    end
    always @(negedge clk) begin
        if (rst_n) begin
            if (dsp_ceab !== acc_prev) ceab_bad++;
            if (dsp_ceab === 1'b1)     ceab_cnt++;
        end
    end

    task automatic push_sample(input logic [17:0] a, input logic [17:0] b, output bit ok);
        bit acc;
        ok = 1'b0;
        s_valid = 1'b1; s_a = a; s_b = b;
        for (int k = 0; k < 64; k++) begin
            acc = (s_ready === 1'b1) && !clr;
            @(posedge clk); #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_block(input logic [3:0][17:0] a, input logic [3:0][17:0] b,
                              input bit gaps, input bit push, output bit ok);
        logic [47:0] sum;
        bit          k_ok;
        sum = '0;
        ok  = 1'b1;
        for (int i = 0; i < NT; i++) begin
            push_sample(a[i], b[i], k_ok);
            ok  = ok && k_ok;
            sum = sum + 48'(a[i]) * 48'(b[i]);
            if (gaps && i < NT - 1) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
        if (push) exp_q.push_back(sum);
    endtask

    task automatic wait_mvalid(output int edges);
        edges = 0;
        while (m_valid !== 1'b1 && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
        if (m_valid !== 1'b1) edges = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b1; s_a = '0; s_b = '0;
        #2 rst_n = 1'b0;
        #10;
        n_checks++;
        if ({m_valid, dsp_ceab, dsp_cem, dsp_cep, dsp_ceopmode} !== 5'b0)
            $display("FAIL reset_ctl: got %b want 00000", {m_valid, dsp_ceab, dsp_cem, dsp_cep, dsp_ceopmode});
        else n_pass++;
        n_checks++;
        if (m_data !== 48'd0) $display("FAIL reset_mdata: got %h want 0", m_data); else n_pass++;
        n_checks++;
        if ({dsp_a, dsp_b, dsp_opmode} !== 44'd0)
            $display("FAIL reset_dsp: got %h want 0", {dsp_a, dsp_b, dsp_opmode});
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL reset_sready: got %b want 1", s_ready); else n_pass++;
    endtask

    task automatic test_continuous;
        bit ok; int edges; logic [47:0] exp;
        m_ready = 1'b1;
        send_block({18'd4, 18'd3, 18'd2, 18'd1}, {4{18'd2}}, 1'b0, 1'b1, ok);
        n_checks++;
        if (!ok) $display("FAIL cont_accept: got timeout want 4 accepts"); else n_pass++;
        wait_mvalid(edges);
        n_checks++;
        if (edges != 4) $display("FAIL cont_latency: got %0d want 4", edges); else n_pass++;
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 48'hx;
        n_checks++;
        if (m_data !== exp) $display("FAIL cont_data: got %0d want %0d", m_data, exp); else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ({m_valid, s_ready} !== 2'b01)
            $display("FAIL cont_release: got m_valid=%b s_ready=%b want 0/1", m_valid, s_ready);
        else n_pass++;
    endtask

    task automatic test_toggle;
        bit ok; int edges; logic [47:0] exp;
        ceab_bad = 0; ceab_cnt = 0;
        send_block({18'd4, 18'd3, 18'd2, 18'd1}, {4{18'd2}}, 1'b1, 1'b1, ok);
        n_checks++;
        if (!ok) $display("FAIL tog_accept: got timeout want 4 accepts"); else n_pass++;
        wait_mvalid(edges);
        n_checks++;
        if (edges != 4) $display("FAIL tog_latency: got %0d want 4", edges); else n_pass++;
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 48'hx;
        n_checks++;
        if (m_data !== exp) $display("FAIL tog_data: got %0d want %0d", m_data, exp); else n_pass++;
        n_checks++;
        if (ceab_bad != 0) $display("FAIL tog_ceab_align: got %0d bad cycles want 0", ceab_bad); else n_pass++;
        n_checks++;
        if (ceab_cnt != NT) $display("FAIL tog_ceab_count: got %0d want %0d", ceab_cnt, NT); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        bit ok; int edges; int hold_bad; logic [47:0] exp;
        m_ready = 1'b0;
        send_block({18'd4, 18'd3, 18'd2, 18'd1}, {4{18'd2}}, 1'b0, 1'b1, ok);
        wait_mvalid(edges);
        n_checks++;
        if (!ok || edges != 4) $display("FAIL bp_latency: got ok=%0d edges=%0d want 1/4", ok, edges); else n_pass++;
        hold_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== exp_q[0]) hold_bad++;
        end
        n_checks++;
        if (hold_bad != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", hold_bad); else n_pass++;
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 48'hx;
        n_checks++;
        if (m_data !== exp) $display("FAIL bp_data: got %0d want %0d", m_data, exp); else n_pass++;
        m_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL bp_release: got %b want 0", m_valid); else n_pass++;
        send_block({4{18'd3}}, {4{18'd3}}, 1'b0, 1'b1, ok);
        wait_mvalid(edges);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 48'hx;
        n_checks++;
        if (!ok || edges != 4 || m_data !== exp)
            $display("FAIL bp_next: got %0d (edges %0d) want %0d", m_data, edges, exp);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_max;
        bit ok; int edges; logic [47:0] exp;
        send_block({4{18'h3FFFF}}, {4{18'h3FFFF}}, 1'b0, 1'b1, ok);
        wait_mvalid(edges);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 48'hx;
        n_checks++;
        if (!ok || edges != 4 || m_data !== exp)
            $display("FAIL max_data: got %h (edges %0d) want %h", m_data, edges, exp);
        else n_pass++;
        n_checks++;
        if (m_data !== 48'h003F_FFE0_0004) $display("FAIL max_const: got %h want 003fffe00004", m_data); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit ok1, ok2, ok; int edges; logic [47:0] exp;
        push_sample(18'd7, 18'd7, ok1);
        push_sample(18'd9, 18'd9, ok2);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok1 || !ok2 || {m_valid, dsp_ceab, dsp_cem} !== 3'b0 || m_data !== 48'd0 || dsp_a !== 18'd0)
            $display("FAIL rstmid_zero: got mv=%b ceab=%b cem=%b md=%h a=%h want all 0",
                     m_valid, dsp_ceab, dsp_cem, m_data, dsp_a);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (s_ready !== 1'b1) $display("FAIL rstmid_sready: got %b want 1", s_ready); else n_pass++;
        send_block({18'd4, 18'd3, 18'd2, 18'd1}, {4{18'd2}}, 1'b0, 1'b1, ok);
        wait_mvalid(edges);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 48'hx;
        n_checks++;
        if (!ok || edges != 4 || m_data !== exp)
            $display("FAIL rstmid_next: got %0d (edges %0d) want %0d", m_data, edges, exp);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_clr;
        bit ok; int edges; int mv_seen; logic [47:0] exp;
        send_block({4{18'd5}}, {4{18'd5}}, 1'b0, 1'b0, ok);
        n_checks++;
        if (s_ready !== 1'b0) $display("FAIL clr_drain: got s_ready=%b want 0", s_ready); else n_pass++;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        n_checks++;
        if (s_ready !== 1'b1 || {dsp_cem, dsp_cep, dsp_ceopmode} !== 3'b0)
            $display("FAIL clr_flush: got s_ready=%b ce=%b want 1/000", s_ready, {dsp_cem, dsp_cep, dsp_ceopmode});
        else n_pass++;
        mv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (m_valid !== 1'b0) mv_seen++;
        end
        n_checks++;
        if (mv_seen != 0) $display("FAIL clr_no_result: got %0d m_valid cycles want 0", mv_seen); else n_pass++;
        send_block({18'd4, 18'd3, 18'd2, 18'd1}, {4{18'd3}}, 1'b0, 1'b1, ok);
        wait_mvalid(edges);
        exp = exp_q.size() > 0 ? exp_q.pop_front() : 48'hx;
        n_checks++;
        if (!ok || edges != 4 || m_data !== exp)
            $display("FAIL clr_next: got %0d (edges %0d) want %0d", m_data, edges, exp);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL sb_empty: got %0d pending want 0", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_toggle();
        test_backpressure();
        test_max();
        test_reset_mid();
        test_clr();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion want finish before 400000");
        $fatal(1, "watchdog expired");
    end

endmodule
